// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the GCD request controller.
package gcd_pkg;

    typedef enum logic [1:0] {
        GCD_REQ_IDLE  = 2'd0,
        GCD_REQ_ISSUE = 2'd1,
        GCD_REQ_DRAIN = 2'd2
    } gcd_req_state_e;

    // Width of a counter that must hold every value 0..timeout_cycles.
    function automatic int unsigned gcd_cnt_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/gcd_req_ctrl_if.sv
// Bundle of the upstream request stream, the GCD core job interface and
// the downstream result stream. The controller uses the master view.
interface gcd_req_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [DATA_WIDTH-1:0] req_a_i;
    logic [DATA_WIDTH-1:0] req_b_i;

    logic [DATA_WIDTH-1:0] operand_a_o;
    logic [DATA_WIDTH-1:0] operand_b_o;
    logic                  gcd_enable_o;
    logic [DATA_WIDTH-1:0] gcd_i;
    logic                  gcd_done_i;

    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [DATA_WIDTH-1:0] res_data_o;
    logic                  res_timeout_o;

    logic                  busy_o;

    modport master (
        input  req_valid_i, req_a_i, req_b_i, gcd_i, gcd_done_i, res_ready_i,
        output req_ready_o, operand_a_o, operand_b_o, gcd_enable_o,
               res_valid_o, res_data_o, res_timeout_o, busy_o
    );

    modport slave (
        output req_valid_i, req_a_i, req_b_i, gcd_i, gcd_done_i, res_ready_i,
        input  req_ready_o, operand_a_o, operand_b_o, gcd_enable_o,
               res_valid_o, res_data_o, res_timeout_o, busy_o
    );

endinterface

// File: rtl/gcd_req_fifo.sv
// Operand-pair FIFO: each entry holds {operand A, operand B}.
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    nreset_i,
    input  logic                    push,
    input  logic [2*DATA_WIDTH-1:0] push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [2*DATA_WIDTH-1:0] head
);

    localparam int unsigned      PTR_W      = $clog2(DEPTH);
    localparam int unsigned      ENTRY_W    = 2 * DATA_WIDTH;
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_req_ctrl.sv
// Initiator side of the GCD core handshake: buffers operand pairs, issues
// one job at a time with a watchdog, and holds each result for downstream.
module gcd_req_ctrl
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic           clk_i,
    input  logic           nreset_i,
    gcd_req_ctrl_if.master bus
);

    localparam int unsigned       CNT_W    = gcd_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    gcd_req_state_e          state_q;
    gcd_req_state_e          state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    issue;
    logic                    finish_done;
    logic                    finish_timeout;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [2*DATA_WIDTH-1:0] fifo_head;

    logic                    enable_q;
    logic [DATA_WIDTH-1:0]   op_a_q;
    logic [DATA_WIDTH-1:0]   op_b_q;
    logic                    res_valid_q;
    logic [DATA_WIDTH-1:0]   res_data_q;
    logic                    res_timeout_q;

    gcd_req_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .nreset_i  (nreset_i),
        .push      (bus.req_valid_i && !fifo_full),
        .push_data ({bus.req_a_i, bus.req_b_i}),
        .pop       (issue),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.req_ready_o   = !fifo_full;
    assign bus.operand_a_o   = op_a_q;
    assign bus.operand_b_o   = op_b_q;
    assign bus.gcd_enable_o  = enable_q;
    assign bus.res_valid_o   = res_valid_q;
    assign bus.res_data_o    = res_data_q;
    assign bus.res_timeout_o = res_timeout_q;
    assign bus.busy_o        = (state_q != GCD_REQ_IDLE) || !fifo_empty;

    // State register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= GCD_REQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and one-cycle job strobes; done beats the watchdog.
    always_comb begin
        state_d        = state_q;
        issue          = 1'b0;
        finish_done    = 1'b0;
        finish_timeout = 1'b0;
        case (state_q)
            GCD_REQ_IDLE: begin
                if (!fifo_empty && !res_valid_q && !bus.gcd_done_i) begin
                    issue   = 1'b1;
                    state_d = GCD_REQ_ISSUE;
                end
            end
            GCD_REQ_ISSUE: begin
                if (bus.gcd_done_i) begin
                    finish_done = 1'b1;
                    state_d     = GCD_REQ_DRAIN;
                end else if (cnt_q == TERMINAL) begin
                    finish_timeout = 1'b1;
                    state_d        = GCD_REQ_DRAIN;
                end
            end
            GCD_REQ_DRAIN: begin
                if (!bus.gcd_done_i) begin
                    state_d = GCD_REQ_IDLE;
                end
            end
            default: state_d = GCD_REQ_IDLE;
        endcase
    end

    // Job request: latch operands and raise enable on issue, drop it on finish.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            enable_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
        end else begin
            if (issue) begin
                enable_q <= 1'b1;
                op_a_q   <= fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
                op_b_q   <= fifo_head[DATA_WIDTH-1:0];
                cnt_q    <= '0;
            end else if (finish_done || finish_timeout) begin
                enable_q <= 1'b0;
            end else if (state_q == GCD_REQ_ISSUE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Result slot: filled on finish, emptied by the downstream handshake.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else if (finish_done) begin
            res_valid_q   <= 1'b1;
            res_data_q    <= bus.gcd_i;
            res_timeout_q <= 1'b0;
        end else if (finish_timeout) begin
            res_valid_q   <= 1'b1;
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
        end else if (res_valid_q && bus.res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gcd_req_ctrl.sv
// Directed bench for gcd_req_ctrl with a behavioural GCD core model.
module tb_gcd_req_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic nreset = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int core_latency = 3;
    bit core_hang    = 1'b0;
    int core_sticky  = 0;

    gcd_req_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    gcd_req_ctrl #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] gcd_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core model: answers after core_latency enabled cycles, holds done
    // core_sticky extra cycles after enable drops; hangs when core_hang.
    initial begin : core_model
        int cnt;
        int hold;
        cnt  = 0;
        hold = 0;
        bus.gcd_done_i = 1'b0;
        bus.gcd_i      = '0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                bus.gcd_done_i = 1'b0;
                cnt  = 0;
                hold = 0;
            end else if (bus.gcd_done_i) begin
                if (!bus.gcd_enable_o) begin
                    if (hold == 0) bus.gcd_done_i = 1'b0;
                    else hold--;
                end
            end else if (bus.gcd_enable_o && !core_hang) begin
                cnt++;
                if (cnt >= core_latency) begin
                    bus.gcd_done_i = 1'b1;
                    bus.gcd_i      = gcd_ref(bus.operand_a_o, bus.operand_b_o);
                    hold = core_sticky;
                    cnt  = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int w = 0;
        bus.req_valid_i = 1'b1;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        while (!bus.req_ready_o && w < 200) begin
            tick();
            w++;
        end
        if (!bus.req_ready_o) check("push_ready_wait", bus.req_ready_o, 1);
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [DW-1:0] exp_data, input logic exp_to);
        int w = 0;
        while (!bus.res_valid_o && w < 300) begin
            tick();
            w++;
        end
        check({tag, "_valid"},   bus.res_valid_o,   1);
        check({tag, "_data"},    bus.res_data_o,    exp_data);
        check({tag, "_timeout"}, bus.res_timeout_o, exp_to);
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_enable"},  bus.gcd_enable_o,  0);
        check({tag, "_rvalid"},  bus.res_valid_o,   0);
        check({tag, "_rdata"},   bus.res_data_o,    0);
        check({tag, "_rtimeout"},bus.res_timeout_o, 0);
        check({tag, "_op_a"},    bus.operand_a_o,   0);
        check({tag, "_op_b"},    bus.operand_b_o,   0);
        check({tag, "_busy"},    bus.busy_o,        0);
        check({tag, "_qready"},  bus.req_ready_o,   1);
    endtask

    // Counts consecutive enable-high samples, starting once enable rises.
    task automatic count_enable(output int n);
        int w = 0;
        n = 0;
        while (!bus.gcd_enable_o && w < 50) begin
            tick();
            w++;
        end
        while (bus.gcd_enable_o && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cyc;
        int n;
        int viol;
        logic [DW-1:0] exp_bp [5];

        bus.req_valid_i = 1'b0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.res_ready_i = 1'b0;

        // Reset values
        repeat (3) tick();
        check_reset("rst");
        nreset = 1'b1;
        tick();

        // Single job, core latency 10
        core_latency = 10;
        push(8'd48, 8'd18);
        check("t1_enable_n1", bus.gcd_enable_o, 0);
        tick();
        check("t1_enable_n2", bus.gcd_enable_o, 1);
        check("t1_op_a", bus.operand_a_o, 48);
        check("t1_op_b", bus.operand_b_o, 18);
        check("t1_busy", bus.busy_o, 1);
        cyc = 0;
        while (!bus.res_valid_o && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t1_latency", cyc, 10);
        check("t1_enable_drop", bus.gcd_enable_o, 0);
        wait_result("t1", 8'd6, 1'b0);
        check("t1_rvalid_clear", bus.res_valid_o, 0);
        check("t1_idle", bus.busy_o, 0);

        // Back-pressure: five pairs with downstream stalled
        core_latency = 3;
        exp_bp = '{8'd4, 8'd1, 8'd9, 8'd25, 8'd7};
        push(8'd12, 8'd8);
        push(8'd7, 8'd5);
        push(8'd0, 8'd9);
        push(8'd100, 8'd75);
        push(8'd21, 8'd14);
        check("t2_full", bus.req_ready_o, 0);
        check("t2_busy", bus.busy_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_hold_valid", bus.res_valid_o, 1);
            check("t2_hold_data", bus.res_data_o, 4);
        end
        check("t2_still_full", bus.req_ready_o, 0);
        for (int i = 0; i < 5; i++) begin
            wait_result($sformatf("t2_res%0d", i), exp_bp[i], 1'b0);
        end

        // Timeout: hung core, then the next job completes normally
        repeat (3) tick();
        core_hang = 1'b1;
        push(8'd9, 8'd6);
        push(8'd15, 8'd10);
        count_enable(n);
        core_hang = 1'b0;
        check("t3_issue_cycles", n, TO);
        wait_result("t3_abort", 8'd0, 1'b1);
        wait_result("t3_next", 8'd5, 1'b0);

        // Done exactly on terminal count: done wins
        repeat (3) tick();
        core_latency = 16;
        push(8'd36, 8'd24);
        count_enable(n);
        check("t4_issue_cycles", n, TO);
        wait_result("t4", 8'd12, 1'b0);

        // Sticky done: no issue until done falls
        repeat (3) tick();
        core_latency = 2;
        core_sticky  = 5;
        push(8'd6, 8'd4);
        push(8'd9, 8'd3);
        wait_result("t5a", 8'd2, 1'b0);
        viol = 0;
        cyc  = 0;
        while (bus.gcd_done_i && cyc < 50) begin
            if (bus.gcd_enable_o) viol++;
            tick();
            cyc++;
        end
        check("t5_done_sticky", (cyc > 0), 1);
        check("t5_no_issue_while_done", viol, 0);
        wait_result("t5b", 8'd3, 1'b0);
        core_sticky = 0;

        // Reset mid-job with three pairs queued
        repeat (3) tick();
        core_hang    = 1'b1;
        core_latency = 3;
        push(8'd1, 8'd1);
        push(8'd2, 8'd2);
        push(8'd3, 8'd3);
        push(8'd4, 8'd4);
        check("t6_enable_pre", bus.gcd_enable_o, 1);
        check("t6_busy_pre", bus.busy_o, 1);
        nreset = 1'b0;
        #1;
        check_reset("t6_rst");
        repeat (2) tick();
        nreset    = 1'b1;
        core_hang = 1'b0;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.res_valid_o || bus.gcd_enable_o || bus.busy_o) viol++;
        end
        check("t6_no_stale_work", viol, 0);
        check("t6_busy_post", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
